// File: rtl/tx_itrpt_pkg.sv
// Shared definitions for the TX interrupt router: per-channel mode encoding.
package tx_itrpt_pkg;

  typedef logic [1:0] itrpt_mode_t;

  localparam itrpt_mode_t MODE_LEVEL  = 2'b00;
  localparam itrpt_mode_t MODE_RISE   = 2'b01;
  localparam itrpt_mode_t MODE_FALL   = 2'b10;
  localparam itrpt_mode_t MODE_STICKY = 2'b11;

endpackage

// File: rtl/tx_itrpt_chan.sv
// One interrupt output channel: source mux, event qualification, pulse stretch,
// sticky latch, mask and saturating event counter.
module tx_itrpt_chan
  import tx_itrpt_pkg::*;
#(
  parameter int NUM_SRC   = 8,
  parameter int SEL_W     = 3,
  parameter int STRETCH_W = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_vec,
  input  logic [NUM_SRC-1:0]   rise_vec,
  input  logic [NUM_SRC-1:0]   fall_vec,
  input  logic [SEL_W-1:0]     src_sel,
  input  logic [1:0]           mode,
  input  logic [STRETCH_W-1:0] stretch_len,
  input  logic                 mask,
  input  logic                 clr,
  output logic                 tx_itrpt,
  output logic                 pending,
  output logic [CNT_W-1:0]     event_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  itrpt_mode_t          mode_cur;
  logic                 sel_level;
  logic                 sel_rise;
  logic                 sel_fall;
  logic                 evt;
  logic [STRETCH_W-1:0] stretch_q;
  logic [STRETCH_W-1:0] stretch_nxt;
  logic                 pend_nxt;
  logic [CNT_W-1:0]     cnt_nxt;

  assign mode_cur = itrpt_mode_t'(mode);

  // Indices at or above NUM_SRC match nothing, so the channel sees a constant 0.
  always_comb begin
    sel_level = 1'b0;
    sel_rise  = 1'b0;
    sel_fall  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_sel == SEL_W'(i)) begin
        sel_level = src_vec[i];
        sel_rise  = rise_vec[i];
        sel_fall  = fall_vec[i];
      end
    end
  end

  assign evt = (mode_cur == MODE_FALL) ? sel_fall : sel_rise;

  always_comb begin
    stretch_nxt = stretch_q;
    pend_nxt    = pending;
    case (mode_cur)
      MODE_LEVEL: begin
        stretch_nxt = '0;
        pend_nxt    = sel_level;
      end
      MODE_RISE, MODE_FALL: begin
        if (evt) begin
          stretch_nxt = stretch_len;
          pend_nxt    = 1'b1;
        end else if (stretch_q != '0) begin
          stretch_nxt = stretch_q - STRETCH_W'(1);
          pend_nxt    = 1'b1;
        end else begin
          pend_nxt    = 1'b0;
        end
      end
      MODE_STICKY: begin
        stretch_nxt = '0;
        pend_nxt    = evt | (pending & ~clr);
      end
      default: begin
        stretch_nxt = '0;
        pend_nxt    = 1'b0;
      end
    endcase
  end

  // A clear coinciding with an event leaves exactly that one event counted.
  always_comb begin
    cnt_nxt = event_cnt;
    if (clr) begin
      cnt_nxt = evt ? CNT_W'(1) : '0;
    end else if (evt && (event_cnt != CNT_MAX)) begin
      cnt_nxt = event_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stretch_q <= '0;
      pending   <= 1'b0;
      tx_itrpt  <= 1'b0;
      event_cnt <= '0;
    end else begin
      stretch_q <= stretch_nxt;
      pending   <= pend_nxt;
      tx_itrpt  <= pend_nxt & ~mask;
      event_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/tx_interrupt_router.sv
// TX interrupt router: registers the source vector once for edge detection and
// feeds NUM_OUT independent channels.
module tx_interrupt_router
  import tx_itrpt_pkg::*;
#(
  parameter int NUM_SRC   = 8,
  parameter int NUM_OUT   = 2,
  parameter int SEL_W     = 3,
  parameter int STRETCH_W = 4,
  parameter int CNT_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             src_vec,
  input  logic [NUM_OUT*SEL_W-1:0]       src_sel,
  input  logic [NUM_OUT*2-1:0]           mode,
  input  logic [NUM_OUT*STRETCH_W-1:0]   stretch_len,
  input  logic [NUM_OUT-1:0]             mask,
  input  logic [NUM_OUT-1:0]             clr,
  output logic [NUM_OUT-1:0]             tx_itrpt,
  output logic [NUM_OUT-1:0]             pending,
  output logic [NUM_OUT*CNT_W-1:0]       event_cnt
);

  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] rise_vec;
  logic [NUM_SRC-1:0] fall_vec;

  // Edges are taken on the whole vector so re-selecting a source never fakes one.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_d <= '0;
    end else begin
      src_d <= src_vec;
    end
  end

  assign rise_vec = src_vec & ~src_d;
  assign fall_vec = ~src_vec & src_d;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_chan
    tx_itrpt_chan #(
      .NUM_SRC   (NUM_SRC),
      .SEL_W     (SEL_W),
      .STRETCH_W (STRETCH_W),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .src_vec     (src_vec),
      .rise_vec    (rise_vec),
      .fall_vec    (fall_vec),
      .src_sel     (src_sel[g*SEL_W +: SEL_W]),
      .mode        (mode[g*2 +: 2]),
      .stretch_len (stretch_len[g*STRETCH_W +: STRETCH_W]),
      .mask        (mask[g]),
      .clr         (clr[g]),
      .tx_itrpt    (tx_itrpt[g]),
      .pending     (pending[g]),
      .event_cnt   (event_cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_tx_interrupt_router.sv
// Directed bench for tx_interrupt_router with six sources so that select
// values 6 and 7 are out of range.
module tb_tx_interrupt_router;

  localparam int NUM_SRC   = 6;
  localparam int NUM_OUT   = 2;
  localparam int SEL_W     = 3;
  localparam int STRETCH_W = 4;
  localparam int CNT_W     = 8;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_SRC-1:0]           src_vec;
  logic [NUM_OUT*SEL_W-1:0]     src_sel;
  logic [NUM_OUT*2-1:0]         mode;
  logic [NUM_OUT*STRETCH_W-1:0] stretch_len;
  logic [NUM_OUT-1:0]           mask;
  logic [NUM_OUT-1:0]           clr;
  logic [NUM_OUT-1:0]           tx_itrpt;
  logic [NUM_OUT-1:0]           pending;
  logic [NUM_OUT*CNT_W-1:0]     event_cnt;

  int checks = 0;
  int errors = 0;
  int hi;

  tx_interrupt_router #(
    .NUM_SRC   (NUM_SRC),
    .NUM_OUT   (NUM_OUT),
    .SEL_W     (SEL_W),
    .STRETCH_W (STRETCH_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_vec     (src_vec),
    .src_sel     (src_sel),
    .mode        (mode),
    .stretch_len (stretch_len),
    .mask        (mask),
    .clr         (clr),
    .tx_itrpt    (tx_itrpt),
    .pending     (pending),
    .event_cnt   (event_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    src_vec     = '0;
    src_sel     = '0;
    mode        = '0;
    stretch_len = '0;
    mask        = '0;
    clr         = '0;

    // reset
    repeat (3) step();
    chk("rst_tx", 32'(tx_itrpt), 32'h0);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_cnt", 32'(event_cnt), 32'h0);
    rst = 1'b0;

    // level mode on ch0 (sel 2); ch1 prepared for pulse mode (sel 4, len 3)
    src_sel[2:0]     = 3'd2;
    mode[1:0]        = 2'b00;
    src_sel[5:3]     = 3'd4;
    mode[3:2]        = 2'b01;
    stretch_len[7:4] = 4'd3;
    step();
    src_vec[2] = 1'b1;
    #1;
    chk("lvl_no_comb_path", 32'(tx_itrpt[0]), 32'h0);
    for (int j = 0; j < 5; j++) begin
      step();
      chk("lvl_high", 32'(tx_itrpt[0]), 32'h1);
    end
    src_vec[2] = 1'b0;
    step();
    chk("lvl_low_after", 32'(tx_itrpt[0]), 32'h0);
    chk("lvl_cnt", 32'(event_cnt[7:0]), 32'd1);

    // single stretched pulse on ch1: 4 cycles high
    hi = 0;
    src_vec[4] = 1'b1;
    step();
    hi += int'(tx_itrpt[1]);
    src_vec[4] = 1'b0;
    repeat (9) begin
      step();
      hi += int'(tx_itrpt[1]);
    end
    chk("stretch_width", 32'(hi), 32'd4);
    chk("stretch_cnt1", 32'(event_cnt[15:8]), 32'd1);

    // clear ch1 counter, then two pulses 2 cycles apart: 6 cycles high, cnt 2
    clr[1] = 1'b1;
    step();
    clr[1] = 1'b0;
    chk("clr_cnt1", 32'(event_cnt[15:8]), 32'd0);
    hi = 0;
    src_vec[4] = 1'b1;
    step();
    hi += int'(tx_itrpt[1]);
    src_vec[4] = 1'b0;
    step();
    hi += int'(tx_itrpt[1]);
    src_vec[4] = 1'b1;
    step();
    hi += int'(tx_itrpt[1]);
    src_vec[4] = 1'b0;
    repeat (8) begin
      step();
      hi += int'(tx_itrpt[1]);
    end
    chk("retrigger_width", 32'(hi), 32'd6);
    chk("retrigger_cnt1", 32'(event_cnt[15:8]), 32'd2);

    // sticky on ch0
    mode[1:0] = 2'b11;
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("sticky_clr0_cnt", 32'(event_cnt[7:0]), 32'd0);
    src_vec[2] = 1'b1;
    step();
    src_vec[2] = 1'b0;
    chk("sticky_set", 32'(pending[0]), 32'h1);
    chk("sticky_cnt", 32'(event_cnt[7:0]), 32'd1);
    repeat (5) step();
    chk("sticky_hold", 32'(pending[0]), 32'h1);
    chk("sticky_hold_tx", 32'(tx_itrpt[0]), 32'h1);
    clr[0] = 1'b1;
    src_vec[2] = 1'b1;
    step();
    clr[0] = 1'b0;
    src_vec[2] = 1'b0;
    chk("clr_evt_pend", 32'(pending[0]), 32'h1);
    chk("clr_evt_cnt", 32'(event_cnt[7:0]), 32'd1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("clr_pend", 32'(pending[0]), 32'h0);
    chk("clr_cnt", 32'(event_cnt[7:0]), 32'd0);
    chk("clr_tx", 32'(tx_itrpt[0]), 32'h0);

    // mask on sticky ch0
    mask[0] = 1'b1;
    src_vec[2] = 1'b1;
    step();
    src_vec[2] = 1'b0;
    chk("mask_tx", 32'(tx_itrpt[0]), 32'h0);
    chk("mask_pend", 32'(pending[0]), 32'h1);
    chk("mask_cnt", 32'(event_cnt[7:0]), 32'd1);
    step();
    chk("mask_tx_hold", 32'(tx_itrpt[0]), 32'h0);
    mask[0] = 1'b0;
    #1;
    chk("unmask_not_comb", 32'(tx_itrpt[0]), 32'h0);
    step();
    chk("unmask_tx", 32'(tx_itrpt[0]), 32'h1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("mask_cleanup", 32'(tx_itrpt[0]), 32'h0);

    // out-of-range select 7 in level mode
    mode[1:0]    = 2'b00;
    src_sel[2:0] = 3'd7;
    src_vec      = 6'h3F;
    repeat (3) begin
      step();
      chk("sel7_tx", 32'(tx_itrpt[0]), 32'h0);
    end
    chk("sel7_pend", 32'(pending[0]), 32'h0);
    chk("sel7_cnt", 32'(event_cnt[7:0]), 32'd0);

    // out-of-range select 6 in rise mode with toggling sources
    mode[1:0]    = 2'b01;
    src_sel[2:0] = 3'd6;
    src_vec = 6'h00;
    step();
    src_vec = 6'h3F;
    step();
    chk("sel6_pend", 32'(pending[0]), 32'h0);
    src_vec = 6'h00;
    step();
    src_vec = 6'h3F;
    step();
    chk("sel6_cnt", 32'(event_cnt[7:0]), 32'd0);

    // switch ch1 from a low source (4) to a held-high source (5)
    src_vec = 6'b100000;
    repeat (6) step();
    clr[1] = 1'b1;
    step();
    clr[1] = 1'b0;
    chk("swsel_pre_cnt", 32'(event_cnt[15:8]), 32'd0);
    chk("swsel_pre_pend", 32'(pending[1]), 32'h0);
    src_sel[5:3] = 3'd5;
    step();
    chk("swsel_pend", 32'(pending[1]), 32'h0);
    step();
    chk("swsel_cnt", 32'(event_cnt[15:8]), 32'd0);

    // counter saturation on ch1: 300 rises on source 4
    src_sel[5:3]     = 3'd4;
    stretch_len[7:4] = 4'd0;
    for (int k = 1; k <= 300; k++) begin
      src_vec = 6'b110000;
      step();
      src_vec = 6'b100000;
      step();
      if (k == 254) chk("sat_254", 32'(event_cnt[15:8]), 32'd254);
      if (k == 255) chk("sat_255", 32'(event_cnt[15:8]), 32'd255);
    end
    chk("sat_300", 32'(event_cnt[15:8]), 32'd255);

    // reset during a long stretch on ch1 and a sticky on ch0
    mode[1:0]        = 2'b11;
    src_sel[2:0]     = 3'd0;
    stretch_len[7:4] = 4'd15;
    src_vec = 6'b110001;
    step();
    src_vec = 6'b100000;
    step();
    chk("pre_rst_stretch", 32'(tx_itrpt[1]), 32'h1);
    chk("pre_rst_sticky", 32'(pending[0]), 32'h1);
    rst = 1'b1;
    step();
    chk("midrst_tx", 32'(tx_itrpt), 32'h0);
    chk("midrst_pend", 32'(pending), 32'h0);
    chk("midrst_cnt", 32'(event_cnt), 32'h0);
    rst = 1'b0;
    step();
    chk("post_rst_pend", 32'(pending), 32'h0);
    chk("post_rst_tx", 32'(tx_itrpt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
